// File: rtl/dpc_bp_collector.sv
// Bad-pixel collector: gathers per-frame defect entries into a local buffer,
// then streams them out as packed table writes once the frame completes.
module dpc_bp_collector #(
    parameter int unsigned CNT_WIDTH   = 10,
    parameter int unsigned AUTO_BP_NUM = 256,
    parameter int unsigned AUTO_BP_BIT = 8
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   enable,
    input  logic                   frame_start,
    input  logic                   frame_done,
    input  logic                   bp_valid,
    output logic                   bp_ready,
    input  logic [CNT_WIDTH-1:0]   bp_x,
    input  logic [CNT_WIDTH-1:0]   bp_y,
    input  logic                   bp_type,
    output logic                   out_wen,
    output logic [AUTO_BP_BIT-1:0] out_waddr,
    output logic [31:0]            out_wdata,
    output logic [AUTO_BP_BIT:0]   out_bp_num,
    output logic                   dump_done,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned EntW = 2 * CNT_WIDTH + 1;
    localparam logic [AUTO_BP_BIT:0] FullCnt = (AUTO_BP_BIT + 1)'(AUTO_BP_NUM);

    typedef enum logic [1:0] {StIdle, StCollect, StDump} state_e;

    state_e                 state_q, state_d;
    logic [EntW-1:0]        mem [AUTO_BP_NUM];
    logic [AUTO_BP_BIT:0]   count_q, count_d, base_cnt;
    logic [AUTO_BP_BIT:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   last_x_q, last_y_q;
    logic                   overflow_q, overflow_d;
    logic                   out_wen_q, dump_done_q;
    logic [AUTO_BP_BIT-1:0] out_waddr_q;
    logic [31:0]            out_wdata_q;
    logic [AUTO_BP_BIT:0]   out_bp_num_q;
    logic                   take, is_full, is_dup, store, start_ok, dump_last;

    function automatic logic [31:0] pack_entry(input logic [EntW-1:0] e);
        logic [31:0] w;
        w                   = '0;
        w[31]               = e[EntW-1];
        w[16 +: CNT_WIDTH]  = e[CNT_WIDTH +: CNT_WIDTH];
        w[0 +: CNT_WIDTH]   = e[CNT_WIDTH-1:0];
        return w;
    endfunction

    // A coincident frame_start empties the buffer before this cycle's entry lands.
    assign start_ok  = frame_start && (state_q != StDump);
    assign base_cnt  = frame_start ? '0 : count_q;
    assign take      = bp_valid && bp_ready && enable && (state_q == StCollect);
    assign is_full   = (base_cnt == FullCnt);
    assign is_dup    = (base_cnt != '0) && (bp_x == last_x_q) && (bp_y == last_y_q);
    assign store     = take && !is_full && !is_dup;
    assign dump_last = (state_q == StDump) && (rd_ptr_q == count_q);

    always_ff @(posedge aclk) begin
        if (areset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (frame_start) state_d = StCollect;
            StCollect: if (frame_done)  state_d = StDump;
            StDump:    if (dump_last)   state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    always_comb begin
        bp_ready = (state_q != StDump);
        busy     = (state_q == StDump);
    end

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_ptr_d   = rd_ptr_q;
        if (start_ok) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end
        if (take && is_full) overflow_d = 1'b1;
        if (store)           count_d    = base_cnt + 1'b1;
        if (state_q != StDump)  rd_ptr_d = '0;
        else if (!dump_last)    rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (store) mem[base_cnt[AUTO_BP_BIT-1:0]] <= {bp_type, bp_y, bp_x};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            count_q      <= '0;
            overflow_q   <= 1'b0;
            rd_ptr_q     <= '0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            out_wen_q    <= 1'b0;
            out_waddr_q  <= '0;
            out_wdata_q  <= '0;
            out_bp_num_q <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            rd_ptr_q    <= rd_ptr_d;
            out_wen_q   <= busy && !dump_last;
            dump_done_q <= dump_last;
            if (store) begin
                last_x_q <= bp_x;
                last_y_q <= bp_y;
            end
            // Buffer read register doubles as the output data register.
            if (busy && !dump_last) begin
                out_waddr_q <= rd_ptr_q[AUTO_BP_BIT-1:0];
                out_wdata_q <= pack_entry(mem[rd_ptr_q[AUTO_BP_BIT-1:0]]);
            end
            if (dump_last) out_bp_num_q <= count_q;
        end
    end

    assign out_wen    = out_wen_q;
    assign out_waddr  = out_waddr_q;
    assign out_wdata  = out_wdata_q;
    assign out_bp_num = out_bp_num_q;
    assign dump_done  = dump_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dpc_bp_collector.sv
// Bench for dpc_bp_collector: frame-level reference model with a per-cycle
// compare, directed corner frames with literal expectations, then random frames.
module tb_dpc_bp_collector;

    localparam int CW  = 10;
    localparam int NUM = 256;
    localparam int BIT = 8;

    logic           aclk = 1'b0;
    logic           areset, enable, frame_start, frame_done, bp_valid, bp_type;
    logic [CW-1:0]  bp_x, bp_y;
    logic           bp_ready, out_wen, dump_done, overflow, busy;
    logic [BIT-1:0] out_waddr;
    logic [31:0]    out_wdata;
    logic [BIT:0]   out_bp_num;

    dpc_bp_collector #(
        .CNT_WIDTH   (CW),
        .AUTO_BP_NUM (NUM),
        .AUTO_BP_BIT (BIT)
    ) u_dut (
        .aclk        (aclk),
        .areset      (areset),
        .enable      (enable),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .bp_valid    (bp_valid),
        .bp_ready    (bp_ready),
        .bp_x        (bp_x),
        .bp_y        (bp_y),
        .bp_type     (bp_type),
        .out_wen     (out_wen),
        .out_waddr   (out_waddr),
        .out_wdata   (out_wdata),
        .out_bp_num  (out_bp_num),
        .dump_done   (dump_done),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    int wen_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 collecting, 2 dumping
    int          cyc = 0;
    int          m_mode = 0;
    int          d_start = 0;
    bit          m_valid = 0;
    bit          m_ovf = 0;
    logic [31:0] frame_q[$];
    logic [31:0] dump_q[$];
    bit          e_wen, e_done;
    logic [31:0] e_addr, e_data, e_num;

    always @(posedge aclk) begin
        int          k, old;
        logic [31:0] w;
        cyc++;
        if (areset) begin
            m_mode = 0; m_ovf = 0; frame_q.delete(); dump_q.delete();
            e_wen = 0; e_done = 0; e_addr = 0; e_data = 0; e_num = 0;
        end else begin
            e_wen = 0;
            e_done = 0;
            if (m_mode == 2) begin
                k = cyc - d_start;
                if (k >= 1 && k <= dump_q.size()) begin
                    e_wen  = 1;
                    e_addr = k - 1;
                    e_data = dump_q[k-1];
                end else if (k == dump_q.size() + 1) begin
                    e_done = 1;
                    e_num  = dump_q.size();
                    m_mode = 0;
                end
            end else begin
                old = m_mode;
                if (frame_start) begin
                    m_mode = 1; m_ovf = 0; frame_q.delete();
                end
                if (bp_valid && enable && old == 1) begin
                    w = (32'(bp_type) << 31) | (32'(bp_y) << 16) | 32'(bp_x);
                    if (frame_q.size() == NUM) m_ovf = 1;
                    else if (frame_q.size() > 0 &&
                             (frame_q[$] & 32'h03FF_03FF) == (w & 32'h03FF_03FF)) ;
                    else frame_q.push_back(w);
                end
                if (frame_done && old == 1) begin
                    m_mode  = 2;
                    d_start = cyc;
                    dump_q  = frame_q;
                end
            end
        end
        m_valid = 1;
    end

    always @(negedge aclk) begin
        if (m_valid) begin
            chk("out_wen",    32'(out_wen),    32'(e_wen));
            chk("out_waddr",  32'(out_waddr),  e_addr);
            chk("out_wdata",  out_wdata,       e_data);
            chk("dump_done",  32'(dump_done),  32'(e_done));
            chk("out_bp_num", 32'(out_bp_num), e_num);
            chk("overflow",   32'(overflow),   32'(m_ovf));
            chk("busy",       32'(busy),       32'(m_mode == 2));
            chk("bp_ready",   32'(bp_ready),   32'(m_mode != 2));
        end
        if (out_wen === 1'b1) wen_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int x, input int y, input bit t);
        bp_valid = 1; bp_x = CW'(x); bp_y = CW'(y); bp_type = t;
        tick();
        bp_valid = 0;
    endtask

    task automatic pulse_start();
        frame_start = 1; tick(); frame_start = 0;
    endtask

    task automatic pulse_done();
        frame_done = 1; tick(); frame_done = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) chk("wait_idle_timeout", 32'd1, 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        areset = 1; enable = 1; frame_start = 0; frame_done = 0;
        bp_valid = 0; bp_x = '0; bp_y = '0; bp_type = 0;
        tick(); tick();
        @(negedge aclk);
        chk("rst_ready", 32'(bp_ready), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_num",   32'(out_bp_num), 32'd0);
        tick();
        areset = 0;
        send(1, 1, 0);                          // idle entry must be dropped
        tick();

        // basic frame
        pulse_start();
        send(5, 7, 0); send(9, 7, 1); send(2, 8, 0);
        pulse_done();
        @(negedge aclk); chk("basic_gap_wen", 32'(out_wen), 32'd0);
        tick(); @(negedge aclk);
        chk("basic_w0", out_wdata, 32'h0007_0005); chk("basic_a0", 32'(out_waddr), 32'd0);
        tick(); @(negedge aclk);
        chk("basic_w1", out_wdata, 32'h8007_0009); chk("basic_a1", 32'(out_waddr), 32'd1);
        tick(); @(negedge aclk);
        chk("basic_w2", out_wdata, 32'h0008_0002); chk("basic_a2", 32'(out_waddr), 32'd2);
        tick(); @(negedge aclk);
        chk("basic_done", 32'(dump_done), 32'd1);
        chk("basic_num",  32'(out_bp_num), 32'd3);
        chk("basic_wen_off", 32'(out_wen), 32'd0);
        tick();

        // duplicate suppression
        pulse_start();
        send(4, 4, 0); send(4, 4, 0);
        wen_seen = 0;
        pulse_done(); wait_idle();
        chk("dup_wen_cnt", 32'(wen_seen), 32'd1);
        chk("dup_num", 32'(out_bp_num), 32'd1);

        // empty frame
        pulse_start(); tick(); tick();
        wen_seen = 0;
        pulse_done();
        @(negedge aclk); chk("empty_done_early", 32'(dump_done), 32'd0);
        tick(); @(negedge aclk);
        chk("empty_done", 32'(dump_done), 32'd1);
        chk("empty_num",  32'(out_bp_num), 32'd0);
        tick();
        chk("empty_wen_cnt", 32'(wen_seen), 32'd0);

        // overflow
        pulse_start();
        for (int i = 0; i < 256; i++) send(i, i / 2, i[0]);
        @(negedge aclk); chk("ovf_before", 32'(overflow), 32'd0);
        send(300, 5, 0);
        @(negedge aclk); chk("ovf_after257", 32'(overflow), 32'd1);
        for (int i = 0; i < 3; i++) send(400 + i, 9, 1);
        wen_seen = 0;
        pulse_done(); wait_idle();
        chk("ovf_wen_cnt", 32'(wen_seen), 32'd256);
        chk("ovf_num", 32'(out_bp_num), 32'd256);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        pulse_start();
        @(negedge aclk); chk("ovf_cleared", 32'(overflow), 32'd0);
        pulse_done(); wait_idle();

        // entry coincident with frame_done, frame_start during dump
        pulse_start();
        send(1, 1, 0);
        bp_valid = 1; bp_x = 3; bp_y = 2; bp_type = 1; frame_done = 1;
        tick();
        bp_valid = 0; frame_done = 0;
        @(negedge aclk); chk("dump_ready_low", 32'(bp_ready), 32'd0);
        frame_start = 1; tick(); frame_start = 0;
        wait_idle();
        chk("corner_last_word", out_wdata, 32'h8002_0003);
        chk("corner_num", 32'(out_bp_num), 32'd2);
        chk("corner_idle", 32'(busy), 32'd0);

        // reset mid-dump after two writes
        pulse_start();
        send(10, 1, 0); send(11, 1, 0); send(12, 1, 0); send(13, 1, 0);
        wen_seen = 0;
        pulse_done(); tick(); tick();
        areset = 1; tick(); areset = 0;
        @(negedge aclk);
        chk("rst_dump_wen",  32'(out_wen), 32'd0);
        chk("rst_dump_busy", 32'(busy), 32'd0);
        chk("rst_dump_rdy",  32'(bp_ready), 32'd1);
        chk("rst_dump_data", out_wdata, 32'd0);
        tick(); tick(); tick();
        chk("rst_dump_wen_cnt", 32'(wen_seen), 32'd2);

        // enable low for a whole frame
        enable = 0;
        pulse_start();
        send(1, 2, 0); send(3, 4, 1); send(5, 6, 0);
        pulse_done(); wait_idle();
        chk("en0_num", 32'(out_bp_num), 32'd0);
        enable = 1;

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            for (int g = 0, gn = $urandom_range(0, 3); g < gn; g++) begin
                bp_valid = $urandom_range(0, 1); bp_x = CW'($urandom_range(0, 3));
                tick();
            end
            pulse_start();
            for (int e = 0, en = $urandom_range(0, 24); e < en; e++) begin
                bp_valid    = ($urandom_range(0, 3) != 0);
                enable      = ($urandom_range(0, 7) != 0);
                frame_start = ($urandom_range(0, 19) == 0);
                bp_x = CW'($urandom_range(0, 3));
                bp_y = CW'($urandom_range(0, 2));
                bp_type = $urandom_range(0, 1);
                tick();
            end
            frame_start = 0;
            bp_valid = $urandom_range(0, 1); bp_x = CW'($urandom_range(0, 1023));
            frame_done = 1; tick(); frame_done = 0;
            for (int n = 0; busy === 1'b1 && n < 100; n++) begin
                frame_start = ($urandom_range(0, 3) == 0);
                bp_valid    = $urandom_range(0, 1);
                tick();
            end
            frame_start = 0; bp_valid = 0; enable = 1;
            wait_idle();
        end

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
